// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU command sequencer.
package alu_pkg;

   typedef logic [7:0]  operand_t;
   typedef logic [15:0] result_t;

   typedef enum logic [2:0] {
      OpNop  = 3'd0,
      OpAdd  = 3'd1,
      OpSub  = 3'd2,
      OpAnd  = 3'd3,
      OpOr   = 3'd4,
      OpXor  = 3'd5,
      OpMul  = 3'd6,
      OpPass = 3'd7
   } opcode_t;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain
   } seq_state_t;

   typedef struct packed {
      opcode_t  op;
      operand_t a;
      operand_t b;
   } cmd_t;

   localparam int unsigned DefCmdDepth      = 4;
   localparam int unsigned DefTimeoutCycles = 16;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO holding packed {op, a, b} entries; pointers carry one extra wrap bit.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = DefCmdDepth
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  cmd_t push_data,
   input  logic pop,
   output cmd_t pop_data,
   output logic full,
   output logic empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   cmd_t          mem [DEPTH];
   logic [AW:0]   wr_ptr_q;
   logic [AW:0]   rd_ptr_q;
   logic          do_push;
   logic          do_pop;

   // Full/empty come from registered pointers only, so a pop never frees space for a same-cycle push.
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands and issues them one at a time, returning tagged results.
// Optional done-timeout abort when ALU_SEQ_TIMEOUT_EN is defined.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned CMD_DEPTH      = DefCmdDepth,
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     cmd_valid,
   output logic     cmd_ready,
   input  operand_t cmd_a,
   input  operand_t cmd_b,
   input  opcode_t  cmd_op,
   output logic     alu_start,
   output operand_t alu_a,
   output operand_t alu_b,
   output opcode_t  alu_op,
   input  logic     alu_done,
   input  result_t  alu_result,
   output logic     rsp_valid,
   input  logic     rsp_ready,
   output result_t  rsp_result,
   output opcode_t  rsp_op,
   output logic     rsp_err
);

   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("CMD_DEPTH must be a power of two and at least 2");
   end
   if (TIMEOUT_CYCLES < 4) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 4");
   end

   seq_state_t state_q;
   cmd_t       cmd_in;
   cmd_t       head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       pop;

   assign cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b};
   assign cmd_ready = !fifo_full;
   // Issue only when the response slot is free or being emptied this cycle.
   assign pop       = (state_q == StIdle) && !fifo_empty && (!rsp_valid || rsp_ready);

   alu_cmd_fifo #(
      .DEPTH(CMD_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (cmd_valid),
      .push_data(cmd_in),
      .pop      (pop),
      .pop_data (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_cnt_q;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         alu_start  <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_op     <= OpNop;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_op     <= OpNop;
`ifdef ALU_SEQ_TIMEOUT_EN
         rsp_err    <= 1'b0;
         tmo_cnt_q  <= '0;
`endif
      end else begin
         if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (pop) begin
                  alu_a     <= head.a;
                  alu_b     <= head.b;
                  alu_op    <= head.op;
                  alu_start <= 1'b1;
                  state_q   <= StIssue;
`ifdef ALU_SEQ_TIMEOUT_EN
                  tmo_cnt_q <= '0;
`endif
               end
            end
            StIssue: begin
               if (alu_done) begin
                  rsp_result <= (alu_op == OpNop) ? '0 : alu_result;
                  rsp_op     <= alu_op;
                  rsp_valid  <= 1'b1;
                  alu_start  <= 1'b0;
                  state_q    <= StDrain;
`ifdef ALU_SEQ_TIMEOUT_EN
                  rsp_err    <= 1'b0;
               end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_result <= '0;
                  rsp_op     <= alu_op;
                  rsp_valid  <= 1'b1;
                  rsp_err    <= 1'b1;
                  alu_start  <= 1'b0;
                  state_q    <= StDrain;
               end else begin
                  tmo_cnt_q  <= tmo_cnt_q + 1'b1;
`endif
               end
            end
            // A late done from the ALU lands here and is dropped.
            StDrain: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and random checks of alu_cmd_sequencer against a queue-based response model.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   localparam int unsigned CmdDepth      = 4;
   localparam int unsigned TimeoutCycles = 16;

   logic     clk = 1'b0;
   logic     reset;
   logic     cmd_valid;
   logic     cmd_ready;
   operand_t cmd_a;
   operand_t cmd_b;
   opcode_t  cmd_op;
   logic     alu_start;
   operand_t alu_a;
   operand_t alu_b;
   opcode_t  alu_op;
   logic     alu_done = 1'b0;
   result_t  alu_result = '0;
   logic     rsp_valid;
   logic     rsp_ready;
   result_t  rsp_result;
   opcode_t  rsp_op;
   logic     rsp_err;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [19:0] exp_q[$];
   logic [19:0] obs_q[$];
   int          alu_lat = 1;
   logic        alu_hang = 1'b0;
   int          alu_cnt = 0;
   logic        rand_ready = 1'b0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(
      .CMD_DEPTH     (CmdDepth),
      .TIMEOUT_CYCLES(TimeoutCycles)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_op    (cmd_op),
      .alu_start (alu_start),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_op    (alu_op),
      .alu_done  (alu_done),
      .alu_result(alu_result),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_result(rsp_result),
      .rsp_op    (rsp_op),
      .rsp_err   (rsp_err)
   );

   function automatic result_t ref_result(opcode_t op, operand_t a, operand_t b);
      case (op)
         OpNop:   return 16'h0000;
         OpAdd:   return 16'(a) + 16'(b);
         OpSub:   return 16'(a) - 16'(b);
         OpAnd:   return {8'h00, a & b};
         OpOr:    return {8'h00, a | b};
         OpXor:   return {8'h00, a ^ b};
         OpMul:   return 16'(a) * 16'(b);
         default: return {a, b};
      endcase
   endfunction

   // ALU model: done after alu_lat start cycles; NOP returns junk that must not reach rsp_result.
   always @(negedge clk) begin
      if (reset || !alu_start || alu_done) begin
         alu_done   = 1'b0;
         alu_cnt    = 0;
         alu_result = 16'($urandom);
      end else begin
         alu_cnt++;
         if (!alu_hang && alu_cnt >= alu_lat) begin
            alu_done   = 1'b1;
            alu_result = (alu_op == OpNop) ? 16'hDEAD : ref_result(alu_op, alu_a, alu_b);
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) obs_q.push_back({rsp_err, rsp_op, rsp_result});
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
   endtask

   // Returns one time unit after the accepting edge.
   task automatic push(input opcode_t op, input operand_t a, input operand_t b);
      logic ok = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         ok = cmd_ready;
         tick();
         if (ok) break;
      end
      cmd_valid = 1'b0;
      check("push_accept", 32'(ok), 32'd1);
      if (ok) exp_q.push_back({1'b0, op, ref_result(op, a, b)});
   endtask

   task automatic drain_compare(input string tag);
      for (int i = 0; i < 3000 && obs_q.size() < exp_q.size(); i++) tick();
      repeat (12) tick();
      check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("%s_rsp%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic count_issue_cycles(output int n);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         if (rsp_valid) break;
         if (alu_start) n++;
         tick();
      end
   endtask

   initial begin
      int n;
      opcode_t ops5[5];
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_op    = OpNop;
      rsp_ready = 1'b0;
      repeat (3) tick();
      check("rst_alu_start", 32'(alu_start), 32'd0);
      check("rst_alu_a", 32'(alu_a), 32'd0);
      check("rst_alu_b", 32'(alu_b), 32'd0);
      check("rst_alu_op", 32'(alu_op), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_result", 32'(rsp_result), 32'd0);
      check("rst_rsp_op", 32'(rsp_op), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      reset = 1'b0;
      tick();

      // ADD, single-cycle ALU, response held for inspection.
      alu_lat = 1;
      push(OpAdd, 8'h12, 8'h34);
      check("add_start_e0", 32'(alu_start), 32'd0);
      tick();
      check("add_start_e1", 32'(alu_start), 32'd1);
      check("add_alu_a", 32'(alu_a), 32'h12);
      check("add_alu_b", 32'(alu_b), 32'h34);
      check("add_alu_op", 32'(alu_op), 32'(OpAdd));
      tick();
      check("add_rsp_valid", 32'(rsp_valid), 32'd1);
      check("add_rsp_result", 32'(rsp_result), 32'h0046);
      check("add_rsp_op", 32'(rsp_op), 32'(OpAdd));
      check("add_rsp_err", 32'(rsp_err), 32'd0);
      check("add_start_off", 32'(alu_start), 32'd0);
      rsp_ready = 1'b1;
      drain_compare("add");

      // MUL with 3-cycle ALU followed by a queued ADD.
      alu_lat = 3;
      push(OpMul, 8'hFF, 8'hFF);
      push(OpAdd, 8'h01, 8'h02);
      count_issue_cycles(n);
      check("mul_issue_cycles", 32'(n), 32'd3);
      check("mul_rsp_result", 32'(rsp_result), 32'hFE01);
      check("mul_start_done", 32'(alu_start), 32'd0);
      tick();
      check("mul_start_drain", 32'(alu_start), 32'd0);
      tick();
      check("next_start", 32'(alu_start), 32'd1);
      check("next_op", 32'(alu_op), 32'(OpAdd));
      drain_compare("mul");

      // Five commands with consumer stalled: FIFO fills, first response held.
      alu_lat   = 1;
      rsp_ready = 1'b0;
      ops5      = '{OpAdd, OpSub, OpMul, OpXor, OpPass};
      foreach (ops5[i]) push(ops5[i], 8'($urandom), 8'($urandom));
      check("full_cmd_ready", 32'(cmd_ready), 32'd0);
      repeat (3) tick();
      check("full_rsp_held", 32'(rsp_valid), 32'd1);
      check("full_rsp_first", 32'(rsp_result), 32'(exp_q[0][15:0]));
      check("full_stall", 32'(alu_start), 32'd0);
      rsp_ready = 1'b1;
      drain_compare("full5");

      // NOP result is forced to zero regardless of the ALU.
      push(OpNop, 8'h5A, 8'hA5);
      push(OpXor, 8'hF0, 8'h0F);
      drain_compare("nop_xor");

`ifdef ALU_SEQ_TIMEOUT_EN
      alu_hang  = 1'b1;
      rsp_ready = 1'b0;
      push(OpAdd, 8'h11, 8'h22);
      exp_q[exp_q.size() - 1] = {1'b1, OpAdd, 16'h0000};
      push(OpXor, 8'h3C, 8'hC3);
      count_issue_cycles(n);
      check("tmo_issue_cycles", 32'(n), 32'(TimeoutCycles));
      check("tmo_rsp_err", 32'(rsp_err), 32'd1);
      check("tmo_rsp_result", 32'(rsp_result), 32'd0);
      check("tmo_rsp_op", 32'(rsp_op), 32'(OpAdd));
      check("tmo_start_off", 32'(alu_start), 32'd0);
      alu_hang  = 1'b0;
      rsp_ready = 1'b1;
      drain_compare("timeout");
`else
      alu_hang  = 1'b1;
      rsp_ready = 1'b1;
      push(OpAdd, 8'h11, 8'h22);
      push(OpXor, 8'h3C, 8'hC3);
      repeat (40) tick();
      check("hang_start", 32'(alu_start), 32'd1);
      check("hang_rsp_valid", 32'(rsp_valid), 32'd0);
      check("hang_rsp_err", 32'(rsp_err), 32'd0);
      alu_hang = 1'b0;
      drain_compare("hang");
`endif

      // Reset while issuing with two commands queued.
      alu_lat   = 3;
      rsp_ready = 1'b1;
      push(OpAdd, 8'h01, 8'h01);
      push(OpSub, 8'h09, 8'h03);
      push(OpOr, 8'h0C, 8'h30);
      check("pre_rst_start", 32'(alu_start), 32'd1);
      reset = 1'b1;
      tick();
      check("mid_rst_start", 32'(alu_start), 32'd0);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      reset = 1'b0;
      exp_q.delete();
      obs_q.delete();
      repeat (20) tick();
      check("post_rst_no_rsp", 32'(obs_q.size()), 32'd0);
      check("post_rst_idle", 32'(alu_start), 32'd0);

      // Random traffic with random ALU latency and consumer back-pressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         alu_lat = int'($urandom_range(1, 4));
         push(opcode_t'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
         repeat ($urandom_range(0, 2)) tick();
      end
      drain_compare("random");
      rand_ready = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

- Sits directly upstream of the ALU.
- Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the ALU's start/done handshake and returns each result, tagged with its opcode, over a valid/ready response interface.
- Optionally aborts hung operations with a done timeout.

## Interface
- CMD_DEPTH, 4: command FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 16: cycles in ISSUE without done before abort (timeout build only); ≥4.
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_a, cmd_b  in  operand_t (8)  operands
- cmd_op  in  opcode_t (3)  operation
- alu_start  out  1  start to ALU, registered
- alu_a, alu_b  out  operand_t  operands to ALU, registered, stable while alu_start=1
- alu_op  out  opcode_t  opcode to ALU, registered
- alu_done  in  1  ALU done
- alu_result  in  result_t (16)  ALU result; valid only while alu_done=1
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_result  out  result_t  captured result
- rsp_op  out  opcode_t  opcode of that result
- rsp_err  out  1  response produced by timeout

## Operation
- **FIFO**
  - Push on cmd_valid && cmd_ready; cmd_ready = !full. No bypass: push into a full FIFO is refused even if a pop occurs the same cycle.
  - Push and pop in the same cycle keep the count unchanged.
  - Pointers are log2(CMD_DEPTH)+1 bits; they wrap modulo 2·CMD_DEPTH.
- **FSM states**
  - IDLE: if FIFO non-empty and (!rsp_valid || rsp_ready), pop the head, load alu_a/b/op, set alu_start=1, go to ISSUE.
  - ISSUE: alu_start held 1. On alu_done=1: capture alu_result into rsp_result, or 16'h0000 when op is NOP. Load rsp_op, set rsp_valid=1 and rsp_err=0, clear alu_start, go to DRAIN.
  - DRAIN: one cycle with alu_start=0; alu_done is ignored (stale). Go to IDLE.
- **Response register**
  - Single entry; cleared on rsp_valid && rsp_ready.
  - A new capture never overwrites an unaccepted response, because IDLE does not issue while the response is held.
- alu_done outside ISSUE is ignored; alu_result is never sampled outside a done cycle.
- **Reset**
  - All outputs 0: alu_start, alu_a, alu_b, alu_op, rsp_valid, rsp_result, rsp_op, rsp_err.
  - cmd_ready=1; FIFO empty; FSM in IDLE.
  - Reset mid-operation drops alu_start the next cycle; the in-flight command, the FIFO contents and any held response are discarded.

## Timing
- Cmd accepted at edge E0 into an empty FIFO, FSM in IDLE → alu_start=1 from E1.
- First sampled alu_done=1 at edge Ek → rsp_valid=1 from Ek and alu_start=0 from Ek. DRAIN lasts Ek..Ek+1; the next alu_start can rise at Ek+2.
- Single-cycle ops (done one cycle after start) → rsp_valid two cycles after acceptance.
- Back-to-back throughput: one command per (ALU latency + 2) cycles when rsp_ready=1.
- rsp_ready held 0 → the FSM stalls in IDLE and the FIFO keeps accepting until full.

## Configuration
- ALU_SEQ_TIMEOUT_EN defined:
  - Counter clears on entry to ISSUE and increments each ISSUE cycle.
  - On reaching TIMEOUT_CYCLES with no done: rsp_valid=1, rsp_err=1, rsp_result=16'h0000, rsp_op=issued op, alu_start=0, go to DRAIN.
  - alu_done in the same cycle as the timeout wins: normal capture, rsp_err=0.
- Not defined: no counter; ISSUE waits indefinitely; rsp_err tied 0 (port kept).

## Structure
- alu_pkg holds:
  - operand_t (logic [7:0]) and result_t (logic [15:0]).
  - opcode_t enum including NOP.
  - seq_state_t enum {IDLE, ISSUE, DRAIN}.
  - TIMEOUT_CYCLES default constant.
- One sub-module: alu_cmd_fifo (parameterised depth; push/pop/full/empty; packs {op, a, b}).

## Test plan
- Reset, then ADD a=8'h12 b=8'h34 → alu_start rises one cycle after acceptance; rsp_valid=1, rsp_result=16'h0046, rsp_op=ADD, rsp_err=0.
- MUL a=8'hFF b=8'hFF with 3-cycle ALU model → alu_start held until done; rsp_result=16'hFE01; alu_start=0 for ≥1 cycle before the next issue.
- Push 5 commands with rsp_ready=0, CMD_DEPTH=4:
  - first response held; cmd_ready=0 once FIFO full.
  - release rsp_ready → all 5 responses returned in order, none lost or duplicated.
- NOP then XOR a=8'hF0 b=8'h0F → responses 16'h0000/NOP then 16'h00FF/XOR.
- ALU model never asserts done, ALU_SEQ_TIMEOUT_EN defined → after 16 ISSUE cycles: rsp_err=1, rsp_result=0, alu_start=0. Next queued command is processed normally.
- Reset asserted while in ISSUE with 2 commands queued → next cycle alu_start=0, rsp_valid=0, cmd_ready=1; no response emitted afterward.
